// File: rtl/lsu_controller.sv
// lsu_controller: load/store sequencer between reservation station and data cache.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
package lsu_pkg;
  typedef enum logic [3:0] {LB, LBU, LH, LHU, LW, SB, SH, SW, ALU} instr_name_e;
endpackage

module lsu_controller
  import lsu_pkg::*;
#(
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  instr_name_e          instr_name,
  input  logic [31:0]          data_1,
  input  logic [31:0]          data_2,
  input  logic [31:0]          immediate,
  input  logic [TAG_WIDTH-1:0] tag,
  output logic                 cache_read,
  output logic                 cache_write,
  output logic [31:0]          cache_address,
  output logic [31:0]          cache_wdata,
  output logic [3:0]           cache_byte_en,
  input  logic                 cache_hit,
  input  logic [31:0]          cache_rdata,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [31:0]          result,
  output logic [TAG_WIDTH-1:0] result_tag,
  output logic                 result_exception
);
  typedef enum logic [1:0] {IDLE, REQUEST, RESPOND} state_e;
  state_e r_state, w_next;
  instr_name_e r_op;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [31:0] r_ea, r_data2, r_result, w_ea, w_ea_al, w_load;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  logic r_exc, w_mem, w_hw, w_wd, w_mis, w_accept, w_store;
  assign w_ea = data_1 + immediate;
  assign w_mem = instr_name inside {LB, LBU, LH, LHU, LW, SB, SH, SW};
  assign w_hw = instr_name inside {LH, LHU, SH};
  assign w_wd = instr_name inside {LW, SW};
  assign w_ea_al = {w_ea[31:2], w_wd ? 2'b00 : {w_ea[1], w_ea[0] & ~w_hw}};
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = w_ea_al != w_ea;
`else
  assign w_mis = 1'b0;
`endif
  assign w_accept = r_state == IDLE && issue_valid && w_mem && !flush;
  assign w_store = r_op inside {SB, SH, SW};
  assign w_byte = cache_rdata[8*r_ea[1:0] +: 8];
  assign w_half = cache_rdata[16*r_ea[1] +: 16];
  assign w_load = r_op == LB  ? {{24{w_byte[7]}}, w_byte} :
                  r_op == LBU ? {24'b0, w_byte} :
                  r_op == LH  ? {{16{w_half[15]}}, w_half} :
                  r_op == LHU ? {16'b0, w_half} : cache_rdata;
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = flush ? IDLE :
             r_state == IDLE    ? (!w_accept ? IDLE : w_mis ? RESPOND : REQUEST) :
             r_state == REQUEST ? (cache_hit ? RESPOND : REQUEST) :
             (result_ready ? IDLE : RESPOND);
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_op <= LB;
      r_tag <= '0;
      r_ea <= '0;
      r_data2 <= '0;
      r_result <= '0;
      r_exc <= 1'b0;
    end else if (w_accept) begin
      r_op <= instr_name;
      r_tag <= tag;
      r_data2 <= data_2;
      r_ea <= w_mis ? w_ea : w_ea_al;
      r_result <= w_ea;
      r_exc <= w_mis;
    end else if (r_state == REQUEST && cache_hit && !flush) begin
      r_result <= w_store ? r_data2 : w_load;
    end
  assign issue_ready = r_state == IDLE;
  assign cache_read = r_state == REQUEST && !w_store;
  assign cache_write = r_state == REQUEST && w_store;
  assign cache_address = {r_ea[31:2], 2'b00};
  assign cache_wdata = !cache_write ? 32'b0 :
                       r_op == SB ? {4{r_data2[7:0]}} :
                       r_op == SH ? {2{r_data2[15:0]}} : r_data2;
  assign cache_byte_en = !cache_write ? 4'b0000 :
                         r_op == SB ? 4'b0001 << r_ea[1:0] :
                         r_op == SH ? (r_ea[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign result_valid = r_state == RESPOND;
  assign result = r_result;
  assign result_tag = r_tag;
  assign result_exception = r_exc;
endmodule

// File: doc/lsu_controller.md
# lsu_controller

Sequencing controller for the load/store execution path, between the load/store reservation station and the data cache port. It accepts one memory instruction at a time and computes its effective address. It drives the cache read/write request until a hit, aligns and extends load data or lane-replicates store data, and presents a tagged result to the result bus under a valid/ready handshake.

## Interface
- TAG_WIDTH, 6, width of the reorder-buffer tag carried with each instruction
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  abandon any in-flight operation (pipeline flush)
- issue_valid  in  1  reservation station presents an instruction
- issue_ready  out  1  controller can accept an instruction
- instr_name  in  instr_name_e  operation: LB, LBU, LH, LHU, LW, SB, SH, SW
- data_1  in  32  base register value
- data_2  in  32  store data
- immediate  in  32  sign-extended offset
- tag  in  TAG_WIDTH  reorder-buffer tag
- cache_read  out  1  read request
- cache_write  out  1  write request
- cache_address  out  32  word-aligned address (bits [1:0] = 0)
- cache_wdata  out  32  store data, replicated into byte lanes
- cache_byte_en  out  4  byte-lane write enables
- cache_hit  in  1  request completed this cycle
- cache_rdata  in  32  read word, valid when cache_hit
- result_valid  out  1  result presented
- result_ready  in  1  result bus accepts
- result  out  32  load value / store data / faulting address
- result_tag  out  TAG_WIDTH  tag of the presented result
- result_exception  out  1  misaligned-access exception flag

## Operation
- States: IDLE, REQUEST, RESPOND.
- IDLE: issue_ready=1. When issue_valid=1 and instr_name is a load/store, latch instr_name, tag, data_2, and ea = data_1 + immediate (mod 2^32) → REQUEST. When instr_name is a non-memory instruction, ignore it and stay in IDLE.
- REQUEST: cache_read (load) or cache_write (store) held at 1 with constant address, wdata and byte_en until cache_hit=1. On hit, capture the formatted result → RESPOND.
- RESPOND: result_valid=1 with result, result_tag and result_exception held stable until result_ready=1 → IDLE.
- Offset is ea[1:0]. cache_address = {ea[31:2],2'b00}.
- Loads: byte = cache_rdata[8*off+:8]; half = cache_rdata[16*off[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
- Stores:
  - SB: wdata = {4{data_2[7:0]}}, byte_en = 1<<off.
  - SH: wdata = {2{data_2[15:0]}}, byte_en = 4'b0011<<(2*off[1]).
  - SW: wdata = data_2, byte_en = 4'b1111.
  - result = data_2.
- Reads: byte_en = 4'b0000, cache_wdata = 0.
- Misalignment handling is set by the macro (see Configuration).
- Priority: reset > flush > normal operation.
- flush in any state → IDLE next cycle. Requests drop, result_valid drops and no result is produced. A store already hit in the flush cycle is not reverted.

## Timing
- Reset values: state IDLE, issue_ready 1, cache_read 0, cache_write 0, cache_address 0, cache_wdata 0, cache_byte_en 0, result_valid 0, result 0, result_tag 0, result_exception 0.
- Accept at edge T. cache request is asserted from T to T+k, where k ≥ 1 is the first cycle sampling cache_hit=1. result_valid is asserted from T+k+1.
- Minimum latency is 2 cycles from accept to result_valid. Minimum issue interval is 3 cycles when result_ready is tied 1.
- issue_ready is a registered function of state only. It is 0 in REQUEST and RESPOND.
- cache_hit is ignored outside REQUEST.
- result_ready is ignored outside RESPOND.
- Back-to-back: result_ready=1 at edge E → IDLE. The next issue can be accepted at E+1.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned means LH/LHU/SH with ea[0]=1, or LW/SW with ea[1:0]≠0.
  - A misaligned instruction goes IDLE → RESPOND directly. No cache request is issued, and no write is issued for stores.
  - The response is result_exception=1, result = ea.
- LSU_MISALIGN_TRAP_EN undefined:
  - ea low bits are forced to natural alignment (halfword: ea[0]=0; word: ea[1:0]=0) before the access.
  - result_exception is tied 0.

## Test plan
- LB: data_1=0x1000, imm=3, cache_rdata=0x80FF_FF00 with hit 2 cycles after request → cache_address=0x1000, result=0xFFFF_FF80, result_valid 3 cycles after accept.
- SH: data_1=0x2000, imm=2, data_2=0x1234_ABCD, hit on first request cycle → cache_write=1, wdata=0xABCD_ABCD, byte_en=4'b1100, result=0x1234_ABCD.
- LHU with result_ready held 0 for 4 cycles, cache_rdata=0x0000_F00F, off=0 → result=0x0000_F00F stable all 4 cycles; issue_ready=0 until the cycle after the ready handshake.
- LW at ea=0x3002 → with macro: no cache request, result_exception=1, result=0x0000_3002. Without macro: cache_address=0x3000, result_exception=0.
- flush asserted while in REQUEST awaiting hit → next cycle cache_read=0, state IDLE, issue_ready=1, no result_valid ever asserted for that tag.
- reset asserted in RESPOND with result_valid=1 → next cycle all outputs at reset values; a subsequent SW completes normally.
